// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - key codes, scanner FSM states and the 4x4 keypad map
package lock_pkg;

  localparam logic [4:0] KEY_BLANK = 5'd10;
  localparam logic [4:0] KEY_STAR  = 5'd11;
  localparam logic [4:0] KEY_HASH  = 5'd12;
  localparam logic [4:0] KEY_A     = 5'd13;
  localparam logic [4:0] KEY_B     = 5'd14;
  localparam logic [4:0] KEY_C     = 5'd15;
  localparam logic [4:0] KEY_D     = 5'd16;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_t;

  function automatic logic [4:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [4:0] code;
    case ({row, col})
      4'h0: code = 5'd1;
      4'h1: code = 5'd2;
      4'h2: code = 5'd3;
      4'h3: code = KEY_A;
      4'h4: code = 5'd4;
      4'h5: code = 5'd5;
      4'h6: code = 5'd6;
      4'h7: code = KEY_B;
      4'h8: code = 5'd7;
      4'h9: code = 5'd8;
      4'hA: code = 5'd9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 5'd0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - counts consecutive match cycles, done on the DEBOUNCE_CYCLES-th
module keypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic match,
  input  logic clr,
  output logic done
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign done = match && !clr && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || !match || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad scanner/debouncer; KEYPAD_REPEAT_EN enables auto-repeat
module keypad_scan
  import lock_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [4:0] num,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  kp_state_t   state, state_nx;
  logic [3:0]  sync1, row_s;
  logic [1:0]  col_idx;
  logic [SW-1:0] scan_cnt;
  logic [3:0]  cap_row;
  logic [1:0]  cap_r;
  logic [1:0]  low_idx;
  logic        scan_last, one_low;
  logic        deb_match, deb_clr, deb_done;
  logic        accept, rep_fire;

  assign col_out   = ~(4'b0001 << col_idx);
  assign scan_last = (scan_cnt == SW'(SCAN_CYCLES - 1));
  assign one_low   = ($countones(~row_s) == 1);
  assign accept    = (state == ST_DEBOUNCE) && deb_done;

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) low_idx = 2'(i);
    end
  end

  keypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .match (deb_match),
    .clr   (deb_clr),
    .done  (deb_done)
  );

  // One debounce counter serves both the press check and the release check.
  always_comb begin
    state_nx  = state;
    deb_match = 1'b0;
    deb_clr   = 1'b1;
    case (state)
      ST_SCAN: begin
        if (scan_last && one_low) state_nx = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        deb_clr   = 1'b0;
        deb_match = (row_s == cap_row);
        if (!deb_match)    state_nx = ST_SCAN;
        else if (deb_done) state_nx = ST_PRESSED;
      end
      ST_PRESSED: begin
        state_nx = ST_RELEASE;
      end
      ST_RELEASE: begin
        deb_clr   = 1'b0;
        deb_match = (row_s == 4'hF);
        if (deb_done) state_nx = ST_SCAN;
      end
      default: state_nx = ST_SCAN;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_CYCLES = 16 * DEBOUNCE_CYCLES;
  localparam int RW = $clog2(REP_CYCLES + 1);

  logic [RW-1:0] rep_cnt;

  // rep_cnt equals cycles since the accept strobe; an all-high row clears it.
  assign rep_fire = (state == ST_RELEASE) && !row_s[cap_r] &&
                    (rep_cnt == RW'(REP_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt <= '0;
    end else if (state == ST_SCAN || state == ST_DEBOUNCE || rep_fire ||
                 (state == ST_RELEASE && row_s == 4'hF)) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 4'hF;
      row_s     <= 4'hF;
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      scan_cnt  <= '0;
      cap_row   <= 4'hF;
      cap_r     <= 2'd0;
      num       <= KEY_BLANK;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      sync1     <= row_in;
      row_s     <= sync1;
      state     <= state_nx;
      key_valid <= accept | rep_fire;
      if (state == ST_SCAN) begin
        if (scan_last) begin
          scan_cnt <= '0;
          if (one_low) begin
            cap_row <= row_s;
            cap_r   <= low_idx;
          end else begin
            col_idx <= col_idx + 1'b1;
          end
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end
      if (accept) begin
        num      <= key_map(cap_r, col_idx);
        key_held <= 1'b1;
      end
      if (state == ST_RELEASE && deb_done) begin
        key_held <= 1'b0;
        col_idx  <= col_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - keypad_scan bench: key matrix model, strobe scoreboard, corner sequences
module tb_keypad_scan;

  localparam int SC = 4;
  localparam int DC = 8;

  typedef struct {
    int         r;
    int         c;
    logic [4:0] code;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [4:0] num;
  logic       key_valid;
  logic       key_held;
  logic [15:0] pressed = '0;

  logic [4:0] exp_q[$];
  logic [4:0] exp_v;
  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;
  logic prev_kv = 1'b0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .num       (num),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // A pressed key shorts its row to its column whenever that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got strobe num=%0d expected none", num);
      end else begin
        exp_v = exp_q.pop_front();
        check("strobe_num", {27'd0, num}, {27'd0, exp_v});
      end
    end
    if (prev_kv && key_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL back_to_back_strobe: got 2 consecutive cycles expected 1");
    end
    prev_kv = key_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_strobe(input string name, input int budget, output int waited);
    int s0;
    s0 = n_strobe;
    waited = 0;
    while (n_strobe == s0 && waited < budget) begin
      tick(1);
      waited++;
    end
    check({name, "_strobe_seen"}, n_strobe - s0, 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (key_held && k < budget) begin
      tick(1);
      k++;
    end
    check({name, "_released"}, {31'd0, key_held}, 0);
  endtask

  task automatic press_key(input string name, input int r, input int c, input logic [4:0] code, input int hold);
    int w;
    exp_q.push_back(code);
    pressed[r*4+c] = 1'b1;
    wait_strobe(name, 100, w);
    check({name, "_held"}, {31'd0, key_held}, 1);
    tick(hold);
    pressed[r*4+c] = 1'b0;
    wait_idle(name, 50);
    tick(4);
  endtask

  vec_t vecs[16];
  int   codes[16] = '{1, 2, 3, 13, 4, 5, 6, 14, 7, 8, 9, 15, 11, 0, 12, 16};

  initial begin
    int   s0, w;
    logic [3:0] seen;

    for (int i = 0; i < 16; i++) vecs[i] = '{i / 4, i % 4, 5'(codes[i])};

    tick(3);
    check("reset_col_out", {28'd0, col_out}, 32'hE);
    check("reset_num", {27'd0, num}, 10);
    check("reset_key_valid", {31'd0, key_valid}, 0);
    check("reset_key_held", {31'd0, key_held}, 0);
    rst = 1'b1;
    tick(3);

    for (int i = 0; i < 16; i++)
      press_key($sformatf("map_r%0dc%0d", vecs[i].r, vecs[i].c), vecs[i].r, vecs[i].c, vecs[i].code, 4);

    // key 5: held, then exact release debounce latency
    exp_q.push_back(5'd5);
    pressed[1*4+1] = 1'b1;
    wait_strobe("key5", 100, w);
    tick(20);
    check("key5_held_while_down", {31'd0, key_held}, 1);
    check("key5_num_stable", {27'd0, num}, 5);
    pressed[1*4+1] = 1'b0;
    tick(9);
    check("key5_held_before_8_clean", {31'd0, key_held}, 1);
    tick(1);
    check("key5_released_after_8_clean", {31'd0, key_held}, 0);
    tick(4);

    press_key("star", 3, 0, 5'd11, 6);
    press_key("keyD", 3, 3, 5'd16, 6);

    // row0 bounce on key 1: low 3, high 1, five times
    s0 = n_strobe;
    for (int k = 0; k < 5; k++) begin
      pressed[0] = 1'b1;
      tick(3);
      pressed[0] = 1'b0;
      tick(1);
    end
    tick(20);
    check("bounce_no_strobe", n_strobe - s0, 0);
    press_key("key1_after_bounce", 0, 0, 5'd1, 4);

    // ghosting: rows 0 and 2 low on column 1
    s0 = n_strobe;
    seen = 4'h0;
    pressed[0*4+1] = 1'b1;
    pressed[2*4+1] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      seen = seen | ~col_out;
    end
    pressed = '0;
    check("ghost_no_strobe", n_strobe - s0, 0);
    check("ghost_cols_rotate", {28'd0, seen}, 32'hF);
    check("ghost_num_kept", {27'd0, num}, 1);
    tick(10);

    // reset during RELEASE of key 9
    exp_q.push_back(5'd9);
    pressed[2*4+2] = 1'b1;
    wait_strobe("key9", 100, w);
    tick(3);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_async_num", {27'd0, num}, 10);
    check("rst_async_key_held", {31'd0, key_held}, 0);
    check("rst_async_col_out", {28'd0, col_out}, 32'hE);
    check("rst_async_key_valid", {31'd0, key_valid}, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    s0 = n_strobe;
    tick(12);
    check("rst_no_early_strobe", n_strobe - s0, 0);
    exp_q.push_back(5'd9);
    wait_strobe("key9_after_rst", 100, w);
    pressed = '0;
    wait_idle("key9_after_rst", 50);
    tick(4);

`ifdef KEYPAD_REPEAT_EN
    for (int k = 0; k < 3; k++) exp_q.push_back(5'd0);
    pressed[3*4+1] = 1'b1;
    wait_strobe("rep0_first", 100, w);
    wait_strobe("rep0_second", 200, w);
    check("rep0_gap1", w, 128);
    wait_strobe("rep0_third", 200, w);
    check("rep0_gap2", w, 128);
    tick(20);
    pressed = '0;
    wait_idle("rep0", 50);
    tick(4);
`endif

    tick(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
